mac_accum_seq: RTL and testbench

- Sequential multiply-accumulate unit; successor to the single-product multiplier in the feature datapath.
- Accepts a stream of (sample x, coefficient a) terms over a valid/ready handshake and forms the signed dot product of up to NUM_TERMS terms.
- Presents the result on an output handshake. Feeds decision-tree node comparators with weighted feature sums.

---
 rtl/mac_accum_seq.sv | 172 +++++++++++++++++
 tb/tb_mac_accum_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_seq.sv
// mac_accum_seq: sequential multiply-accumulate unit.
// Streams (x, a) terms over a valid/ready handshake, forms the signed dot
// product of up to NUM_TERMS terms and presents it on an output handshake.
// Two-stage datapath: the product is registered, then added into the
// accumulator on the following cycle.
module mac_accum_seq #(
    parameter int WIDTH_X   = 10,
    parameter int WIDTH_A   = 4,
    parameter int NUM_TERMS = 8,
    parameter int SIGNED_A  = 1,
    parameter int CNT_W     = $clog2(NUM_TERMS) + 1,
    parameter int WIDTH_Y   = WIDTH_X + WIDTH_A + CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_X-1:0] x,
    input  logic [WIDTH_A-1:0] a,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_Y-1:0] y,
    output logic [CNT_W-1:0]   out_count
);

    // Product width: (WIDTH_X+1) x (WIDTH_A+1) signed operands, where x is
    // never negative, so one bit less than the full product suffices.
    localparam int WIDTH_P = WIDTH_X + WIDTH_A + 1;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;

    logic signed [WIDTH_X:0]     w_x_ext;
    logic signed [WIDTH_A:0]     w_a_ext;
    logic signed [WIDTH_P-1:0]   w_x_wide;
    logic signed [WIDTH_P-1:0]   w_a_wide;
    logic signed [WIDTH_P-1:0]   w_prod;
    logic signed [WIDTH_Y-1:0]   w_prod_ext;
    logic [CNT_W-1:0]            w_count_inc;
    logic                        w_accept;
    logic                        w_last;
    logic                        w_handshake;

    logic signed [WIDTH_P-1:0]   r_prod;
    logic signed [WIDTH_Y-1:0]   r_acc;
    logic [CNT_W-1:0]            r_count;
    logic                        r_in_ready;
    logic                        r_out_valid;
    logic [WIDTH_Y-1:0]          r_y;
    logic [CNT_W-1:0]            r_out_count;

    // Operand widening: x is always zero-extended, a follows SIGNED_A.
    assign w_x_ext = $signed({1'b0, x});
    assign w_a_ext = (SIGNED_A != 0) ? $signed({a[WIDTH_A-1], a}) : $signed({1'b0, a});

    // Bring both operands to the product width so the multiply is exact there.
    assign w_x_wide = {{(WIDTH_P-WIDTH_X-1){1'b0}}, w_x_ext};
    assign w_a_wide = {{(WIDTH_P-WIDTH_A-1){w_a_ext[WIDTH_A]}}, w_a_ext};
    assign w_prod   = w_x_wide * w_a_wide;

    // Sign-extend the registered product to accumulator width.
    assign w_prod_ext = {{(WIDTH_Y-WIDTH_P){r_prod[WIDTH_P-1]}}, r_prod};

    assign w_count_inc = r_count + CNT_W'(1);
    assign w_accept    = in_valid && (r_state == ST_ACCUM);
    // A term closes the sum on in_last or when it fills the last slot.
    assign w_last      = in_last || (w_count_inc == CNT_W'(NUM_TERMS));
    assign w_handshake = r_out_valid && out_ready;

    // Next-state decode for the accumulate / flush / drain / output sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ACCUM: begin
                if (w_accept && w_last) begin
                    w_next_state = ST_FLUSH;
                end else begin
                    w_next_state = ST_ACCUM;
                end
            end
            ST_FLUSH:  w_next_state = ST_DRAIN;
            ST_DRAIN:  w_next_state = ST_OUTPUT;
            ST_OUTPUT: begin
                if (w_handshake) begin
                    w_next_state = ST_ACCUM;
                end else begin
                    w_next_state = ST_OUTPUT;
                end
            end
            default:   w_next_state = ST_ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: load the product stage, fold the previous product into the sum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prod  <= '0;
            r_acc   <= '0;
            r_count <= '0;
        end else if (r_state == ST_OUTPUT) begin
            // Sum is frozen while presented; cleared once it is taken.
            r_prod <= '0;
            if (w_handshake) begin
                r_acc   <= '0;
                r_count <= '0;
            end else begin
                r_acc   <= r_acc;
                r_count <= r_count;
            end
        end else begin
            // Idle cycles load zero so a gap adds nothing on the next cycle.
            r_acc <= r_acc + w_prod_ext;
            if (w_accept) begin
                r_prod  <= w_prod;
                r_count <= w_count_inc;
            end else begin
                r_prod  <= '0;
                r_count <= r_count;
            end
        end
    end

    // Input ready: high exactly while the unit will be accumulating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_next_state == ST_ACCUM);
        end
    end

    // Result register: capture the settled sum in the first OUTPUT cycle,
    // hold it under backpressure, drop valid after the handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_out_count <= '0;
        end else if ((r_state == ST_OUTPUT) && !r_out_valid) begin
            r_out_valid <= 1'b1;
            r_y         <= r_acc;
            r_out_count <= r_count;
        end else if (w_handshake) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign out_count = r_out_count;

endmodule

// File: tb/tb_mac_accum_seq.sv
// Testbench for mac_accum_seq: a signed-coefficient and an unsigned-coefficient
// instance share identical stimulus; a transaction-level model predicts
// in_ready, out_valid, y and out_count every cycle.
module tb_mac_accum_seq;

    localparam int WX = 10;
    localparam int WA = 4;
    localparam int NT = 4;
    localparam int CW = $clog2(NT) + 1;
    localparam int WY = WX + WA + CW;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_last   = 1'b0;
    logic          out_ready = 1'b1;
    logic [WX-1:0] x         = '0;
    logic [WA-1:0] a         = '0;

    logic          in_ready_s, out_valid_s, in_ready_u, out_valid_u;
    logic [WY-1:0] y_s, y_u;
    logic [CW-1:0] cnt_s, cnt_u;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int     m_phase;     // 0 taking terms, 1 waiting for result, 2 presenting
    int     m_cd;
    int     m_n;
    longint m_acc_s, m_acc_u, m_y_s, m_y_u;
    int     m_cnt;
    bit     m_valid, m_ready;

    mac_accum_seq #(.WIDTH_X(WX), .WIDTH_A(WA), .NUM_TERMS(NT), .SIGNED_A(1)) u_dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .x(x), .a(a), .in_last(in_last), .out_valid(out_valid_s),
        .out_ready(out_ready), .y(y_s), .out_count(cnt_s)
    );

    mac_accum_seq #(.WIDTH_X(WX), .WIDTH_A(WA), .NUM_TERMS(NT), .SIGNED_A(0)) u_dut_u (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_u),
        .x(x), .a(a), .in_last(in_last), .out_valid(out_valid_u),
        .out_ready(out_ready), .y(y_u), .out_count(cnt_u)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic model_clear();
        m_phase = 0; m_cd = 0; m_n = 0;
        m_acc_s = 0; m_acc_u = 0; m_y_s = 0; m_y_u = 0; m_cnt = 0;
        m_valid = 1'b0; m_ready = 1'b1;
    endtask

    // Predict the state after the coming rising edge from the current inputs.
    task automatic model_step();
        int xi, sa, ua;
        xi = int'(x);
        sa = int'($signed(a));
        ua = int'(a);
        case (m_phase)
            0: if (in_valid) begin
                   m_acc_s += longint'(xi * sa);
                   m_acc_u += longint'(xi * ua);
                   m_n++;
                   if (in_last || m_n == NT) begin
                       m_phase = 1;
                       m_cd    = 3;
                   end
               end
            1: begin
                   m_cd--;
                   if (m_cd == 0) begin
                       m_phase = 2;
                       m_valid = 1'b1;
                       m_y_s = m_acc_s; m_y_u = m_acc_u; m_cnt = m_n;
                   end
               end
            default: if (out_ready) begin
                   m_valid = 1'b0; m_phase = 0;
                   m_acc_s = 0; m_acc_u = 0; m_n = 0;
               end
        endcase
        m_ready = (m_phase == 0);
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        if (!reset) model_clear();
        check("in_ready_s", in_ready_s, m_ready);
        check("in_ready_u", in_ready_u, m_ready);
        check("out_valid_s", out_valid_s, m_valid);
        check("out_valid_u", out_valid_u, m_valid);
        if (m_valid) begin
            check("y_s", longint'($signed(y_s)), m_y_s);
            check("y_u", longint'($signed(y_u)), m_y_u);
            check("out_count_s", cnt_s, m_cnt);
            check("out_count_u", cnt_u, m_cnt);
        end
        if (reset) model_step();
    end

    // Offer one term and hold it until accepted (bounded).
    task automatic send(input logic [WX-1:0] tx, input logic [WA-1:0] ta, input bit tl);
        int k = 0;
        in_valid = 1'b1; x = tx; a = ta; in_last = tl;
        @(negedge clk);
        while (!in_ready_s && k < 50) begin
            k++;
            @(negedge clk);
        end
        check("send_ready", in_ready_s, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        x = WX'($urandom); a = WA'($urandom);
    endtask

    // Wait (bounded) for a result and pin it against hand-computed literals.
    task automatic wait_out(input string nm, input longint ey_s, input longint ey_u,
                            input int ec, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid_s && lat < 40);
        check({nm, "_valid"}, out_valid_s, 1);
        check({nm, "_y_s"}, longint'($signed(y_s)), ey_s);
        check({nm, "_y_u"}, longint'($signed(y_u)), ey_u);
        check({nm, "_cnt"}, cnt_s, ec);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        model_clear();
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_y", y_s, 0);
        check("rst_cnt", cnt_s, 0);
        check("rst_valid", out_valid_s, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;

        // Count limit, and latency of 3 edges after the 4th accept.
        repeat (4) send(10'd1023, 4'h8, 1'b0);
        wait_out("limit", -32736, 32736, 4, lat);
        check("limit_latency", lat, 4);

        // Early last, then a fresh sum with no residue.
        send(10'd3, 4'h5, 1'b0);
        send(10'd10, 4'hE, 1'b1);
        wait_out("early", -5, 155, 2, lat);
        send(10'd1, 4'h1, 1'b1);
        wait_out("fresh", 1, 1, 1, lat);

        // Backpressure: result held, one handshake when released.
        out_ready = 1'b0;
        send(10'd7, 4'h3, 1'b1);
        wait_out("bp", 21, 21, 1, lat);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_hold_y", longint'($signed(y_s)), 21);
            check("bp_hold_cnt", cnt_s, 1);
            check("bp_hold_ready", in_ready_s, 0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_drop_valid", out_valid_s, 0);
        check("bp_ready_back", in_ready_s, 1);
        @(negedge clk);
        check("bp_single_hs", out_valid_s, 0);
        @(posedge clk); #1 out_ready = 1'b1;

        // Unsigned-coefficient case (signed instance sees a = -1).
        repeat (3) send(10'd1023, 4'hF, 1'b0);
        send(10'd0, 4'h5, 1'b0);
        wait_out("unsigned", -3069, 46035, 4, lat);

        // Input gaps with a stray in_last while idle.
        send(10'd2, 4'h3, 1'b0);
        in_last = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        in_last = 1'b0;
        send(10'd4, 4'hF, 1'b1);
        wait_out("gaps", 2, 66, 2, lat);

        // Reset mid-sum: the aborted sum never produces a result.
        send(10'd9, 4'h2, 1'b0);
        send(10'd9, 4'h2, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_valid", out_valid_s, 0);
        end
        @(posedge clk); #1;
        send(10'd5, 4'h7, 1'b1);
        wait_out("after_rst", 35, 35, 1, lat);

        // Randomized traffic checked by the per-cycle model.
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            x         = WX'($urandom);
            a         = WA'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 149) != 0);
            @(posedge clk); #1;
        end
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) begin @(posedge clk); #1; end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
